// File: rtl/hour_count_cfg.sv
// Configurable hour-of-day counter with 12/24 h display encoding, load, manual advance and day pulse.
// Optional alarm-hour match output when ALARM_MATCH_EN is defined.
module hour_count_cfg #(
   parameter int unsigned DIG_W       = 7,
   parameter bit          DEFAULT_24H = 1'b0,
   parameter int unsigned RST_HOUR    = 0,
   parameter bit          LEAD_BLANK  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enb,
   input  logic             adv_hr,
   input  logic             set_en,
   input  logic [4:0]       set_hour,
   input  logic             mode_24,
   output logic [DIG_W-1:0] h0,
   output logic [DIG_W-1:0] h1,
   output logic [DIG_W-1:0] am_pm,
   output logic             day_tick
`ifdef ALARM_MATCH_EN
   ,
   input  logic [4:0]       alarm_hour,
   output logic             alarm_hit
`endif
);

   localparam logic [DIG_W-1:0] BLANK  = {1'b1, {(DIG_W-1){1'b0}}};
   localparam logic [4:0]       RST_HR = 5'(RST_HOUR);

   function automatic logic [3*DIG_W-1:0] encode(input logic [4:0] hr, input logic m24);
      logic [4:0]       d;
      logic [4:0]       ones;
      logic [1:0]       tens;
      logic [DIG_W-1:0] t_dig;
      logic [DIG_W-1:0] ap;
      if (m24)               d = hr;
      else if (hr == 5'd0)   d = 5'd12;
      else if (hr > 5'd12)   d = hr - 5'd12;
      else                   d = hr;
      if (d >= 5'd20)        tens = 2'd2;
      else if (d >= 5'd10)   tens = 2'd1;
      else                   tens = 2'd0;
      ones  = d - (5'(tens) * 5'd10);
      t_dig = (LEAD_BLANK && (tens == 2'd0)) ? BLANK : DIG_W'(tens);
      ap    = m24 ? BLANK : ((hr < 5'd12) ? DIG_W'(10) : DIG_W'(11));
      return {t_dig, DIG_W'(ones), ap};
   endfunction

   localparam logic [3*DIG_W-1:0] RST_ENC = encode(RST_HR, DEFAULT_24H);

   logic [4:0]         hr_q, hr_d;
   logic               mode_q;
   logic               adv_q;
   logic               tick_d;
   logic               adv;
   logic [3*DIG_W-1:0] enc_d;
   logic               enc_upd;

   always_comb begin
      adv    = enb | (adv_hr & ~adv_q);
      hr_d   = hr_q;
      tick_d = 1'b0;
      if (set_en) begin
         if (set_hour <= 5'd23) hr_d = set_hour;
      end else if (adv) begin
         hr_d   = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
         tick_d = enb & (hr_q == 5'd23);
      end
      enc_d   = encode(hr_d, mode_24);
      // Outputs always equal encode(hr_q, mode_q), so re-encoding is only needed on a change.
      enc_upd = (hr_d != hr_q) || (mode_24 != mode_q);
   end

`ifdef ALARM_MATCH_EN
   logic hit_d;
   always_comb hit_d = (hr_d != hr_q) && (alarm_hour <= 5'd23) && (hr_d == alarm_hour);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alarm_hit <= 1'b0;
      else        alarm_hit <= hit_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hr_q            <= RST_HR;
         mode_q          <= DEFAULT_24H;
         adv_q           <= 1'b0;
         day_tick        <= 1'b0;
         {h1, h0, am_pm} <= RST_ENC;
      end else begin
         hr_q     <= hr_d;
         mode_q   <= mode_24;
         adv_q    <= adv_hr;
         day_tick <= tick_d;
         if (enc_upd) {h1, h0, am_pm} <= enc_d;
      end
   end

endmodule
